axi_lite_reg_bridge: RTL and testbench

//  AXI4-Lite slave front end for register targets: converts AXI read/write transactions into

---
 rtl/axi_lite_reg_bridge_if.sv | 59 +++++
 rtl/axi_lite_reg_bridge.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_bridge_if.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_bridge_if
//   AXI4-Lite bus bundle between a bus master and the register bridge.
//   Only the five channels' address/data/handshake/response signals are
//   carried; protection bits are not part of this bundle.
//
//   Parameters : ADDR_WIDTH (address width), DATA_WIDTH (data width, 32/64)
//   Channels   : AW (s_awaddr, s_awvalid, s_awready)
//                W  (s_wdata, s_wstrb, s_wvalid, s_wready)
//                B  (s_bresp, s_bvalid, s_bready)
//                AR (s_araddr, s_arvalid, s_arready)
//                R  (s_rdata, s_rresp, s_rvalid, s_rready)
//   Modports   : master (drives requests, accepts responses)
//                slave  (accepts requests, drives responses)
// ----------------------------------------------------------------------------
interface axi_lite_reg_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;

    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;

    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;

    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;

    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;

    modport master (
        output s_awaddr, s_awvalid, input  s_awready,
        output s_wdata, s_wstrb, s_wvalid, input  s_wready,
        input  s_bresp, s_bvalid, output s_bready,
        output s_araddr, s_arvalid, input  s_arready,
        input  s_rdata, s_rresp, s_rvalid, output s_rready
    );

    modport slave (
        input  s_awaddr, s_awvalid, output s_awready,
        input  s_wdata, s_wstrb, s_wvalid, output s_wready,
        output s_bresp, s_bvalid, input  s_bready,
        input  s_araddr, s_arvalid, output s_arready,
        output s_rdata, s_rresp, s_rvalid, input  s_rready
    );

endinterface

// File: rtl/axi_lite_reg_bridge.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_bridge
//   AXI4-Lite slave front end for a register block. Each accepted write
//   becomes a one-cycle o_wr strobe with register index, data and byte
//   enables; each accepted read becomes a one-cycle o_rd strobe whose
//   combinational i_rdata is captured and returned on the R channel.
//   Reads and writes run in independent FSMs, one transaction in flight
//   per channel. Addresses outside the block get DECERR and no strobe.
//
//   Ports:
//     clk      : clock
//     nreset   : asynchronous active-low reset
//     s        : AXI4-Lite slave modport (AW/W/B/AR/R channels)
//     o_wr     : one-cycle write strobe to the register target
//     o_wreg   : write register index (qualified by o_wr)
//     o_wdata  : write data (qualified by o_wr)
//     o_wstrb  : write byte enables (qualified by o_wr)
//     o_rd     : one-cycle read strobe to the register target
//     o_rreg   : read register index (qualified by o_rd)
//     i_rdata  : target read data, combinational from o_rreg
// ----------------------------------------------------------------------------
module axi_lite_reg_bridge #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    R_ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] BASE_MASK    = 32'hffff_ffc0
) (
    input  logic                      clk,
    input  logic                      nreset,
    axi_lite_reg_bridge_if.slave      s,
    output logic                      o_wr,
    output logic [R_ADDR_WIDTH-1:0]   o_wreg,
    output logic [DATA_WIDTH-1:0]     o_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_wstrb,
    output logic                      o_rd,
    output logic [R_ADDR_WIDTH-1:0]   o_rreg,
    input  logic [DATA_WIDTH-1:0]     i_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AL         = $clog2(STRB_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_STROBE, W_RESP} wState_e;
    typedef enum logic [1:0] {R_IDLE, R_STROBE, R_RESP} rState_e;

    wState_e                 wState_q, wState_d;
    logic                    awHeld_q, awHeld_d;
    logic                    wHeld_q, wHeld_d;
    logic [ADDR_WIDTH-1:0]   awAddr_q, awAddr_d;
    logic [DATA_WIDTH-1:0]   wData_q, wData_d;
    logic [STRB_WIDTH-1:0]   wStrb_q, wStrb_d;
    logic                    wHit_q, wHit_d;
    logic                    awReady_q, awReady_d;
    logic                    wReady_q, wReady_d;
    logic                    bValid_q, bValid_d;
    logic [1:0]              bResp_q, bResp_d;
    logic                    wr_q, wr_d;
    logic [R_ADDR_WIDTH-1:0] wReg_q, wReg_d;
    logic [DATA_WIDTH-1:0]   oWdata_q, oWdata_d;
    logic [STRB_WIDTH-1:0]   oWstrb_q, oWstrb_d;

    rState_e                 rState_q, rState_d;
    logic                    rHit_q, rHit_d;
    logic                    arReady_q, arReady_d;
    logic                    rValid_q, rValid_d;
    logic [1:0]              rResp_q, rResp_d;
    logic [DATA_WIDTH-1:0]   rData_q, rData_d;
    logic                    rd_q, rd_d;
    logic [R_ADDR_WIDTH-1:0] rReg_q, rReg_d;

    logic                    arHitNow;

    // The read address is decoded straight off the bus on its handshake
    // cycle, so no read address register is needed.
    assign arHitNow = (s.s_araddr & BASE_MASK) == BASE_ADDR;

    // Write channel FSM. AW and W are collected independently in W_IDLE in
    // any order; each ready falls once its beat is held so a second beat
    // cannot overwrite it. Once both are held the strobe fields are loaded
    // for the single W_STROBE cycle, then B is presented until the master
    // accepts it, and only then are AW/W re-opened.
    always_comb begin
        wState_d  = wState_q;
        awHeld_d  = awHeld_q;
        wHeld_d   = wHeld_q;
        awAddr_d  = awAddr_q;
        wData_d   = wData_q;
        wStrb_d   = wStrb_q;
        wHit_d    = wHit_q;
        awReady_d = awReady_q;
        wReady_d  = wReady_q;
        bValid_d  = bValid_q;
        bResp_d   = bResp_q;
        wr_d      = 1'b0;
        wReg_d    = wReg_q;
        oWdata_d  = oWdata_q;
        oWstrb_d  = oWstrb_q;

        case (wState_q)
            W_IDLE: begin
                if (awReady_q && s.s_awvalid) begin
                    awHeld_d = 1'b1;
                    awAddr_d = s.s_awaddr;
                end
                if (wReady_q && s.s_wvalid) begin
                    wHeld_d = 1'b1;
                    wData_d = s.s_wdata;
                    wStrb_d = s.s_wstrb;
                end
                awReady_d = !awHeld_d;
                wReady_d  = !wHeld_d;
                if (awHeld_d && wHeld_d) begin
                    wState_d = W_STROBE;
                    wHit_d   = (awAddr_d & BASE_MASK) == BASE_ADDR;
                    if (wHit_d) begin
                        wr_d     = 1'b1;
                        wReg_d   = awAddr_d[R_ADDR_WIDTH+AL-1:AL];
                        oWdata_d = wData_d;
                        oWstrb_d = wStrb_d;
                    end
                end
            end
            W_STROBE: begin
                bValid_d = 1'b1;
                bResp_d  = wHit_q ? RESP_OKAY : RESP_DECERR;
                wState_d = W_RESP;
            end
            W_RESP: begin
                if (s.s_bready) begin
                    bValid_d  = 1'b0;
                    awHeld_d  = 1'b0;
                    wHeld_d   = 1'b0;
                    awReady_d = 1'b1;
                    wReady_d  = 1'b1;
                    wState_d  = W_IDLE;
                end
            end
            default: begin
                wState_d = W_IDLE;
            end
        endcase
    end

    // Read channel FSM. One AR is taken in R_IDLE and decoded immediately,
    // so o_rd/o_rreg appear in R_STROBE while the target drives i_rdata,
    // which is captured on that cycle's closing edge. The R beat is then
    // held until the master accepts it.
    always_comb begin
        rState_d  = rState_q;
        rHit_d    = rHit_q;
        arReady_d = arReady_q;
        rValid_d  = rValid_q;
        rResp_d   = rResp_q;
        rData_d   = rData_q;
        rd_d      = 1'b0;
        rReg_d    = rReg_q;

        case (rState_q)
            R_IDLE: begin
                arReady_d = 1'b1;
                if (arReady_q && s.s_arvalid) begin
                    arReady_d = 1'b0;
                    rHit_d    = arHitNow;
                    rState_d  = R_STROBE;
                    if (arHitNow) begin
                        rd_d   = 1'b1;
                        rReg_d = s.s_araddr[R_ADDR_WIDTH+AL-1:AL];
                    end
                end
            end
            R_STROBE: begin
                rValid_d = 1'b1;
                rResp_d  = rHit_q ? RESP_OKAY : RESP_DECERR;
                rData_d  = rHit_q ? i_rdata : '0;
                rState_d = R_RESP;
            end
            R_RESP: begin
                if (s.s_rready) begin
                    rValid_d  = 1'b0;
                    arReady_d = 1'b1;
                    rState_d  = R_IDLE;
                end
            end
            default: begin
                rState_d = R_IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything, which also
    // abandons any transaction in flight; readies come back one cycle after
    // release because the idle states re-raise them from the cleared value.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wState_q  <= W_IDLE;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            wHit_q    <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bResp_q   <= 2'b00;
            wr_q      <= 1'b0;
            wReg_q    <= '0;
            oWdata_q  <= '0;
            oWstrb_q  <= '0;
            rState_q  <= R_IDLE;
            rHit_q    <= 1'b0;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rResp_q   <= 2'b00;
            rData_q   <= '0;
            rd_q      <= 1'b0;
            rReg_q    <= '0;
        end else begin
            wState_q  <= wState_d;
            awHeld_q  <= awHeld_d;
            wHeld_q   <= wHeld_d;
            awAddr_q  <= awAddr_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            wHit_q    <= wHit_d;
            awReady_q <= awReady_d;
            wReady_q  <= wReady_d;
            bValid_q  <= bValid_d;
            bResp_q   <= bResp_d;
            wr_q      <= wr_d;
            wReg_q    <= wReg_d;
            oWdata_q  <= oWdata_d;
            oWstrb_q  <= oWstrb_d;
            rState_q  <= rState_d;
            rHit_q    <= rHit_d;
            arReady_q <= arReady_d;
            rValid_q  <= rValid_d;
            rResp_q   <= rResp_d;
            rData_q   <= rData_d;
            rd_q      <= rd_d;
            rReg_q    <= rReg_d;
        end
    end

    assign s.s_awready = awReady_q;
    assign s.s_wready  = wReady_q;
    assign s.s_bvalid  = bValid_q;
    assign s.s_bresp   = bResp_q;
    assign s.s_arready = arReady_q;
    assign s.s_rvalid  = rValid_q;
    assign s.s_rresp   = rResp_q;
    assign s.s_rdata   = rData_q;

    assign o_wr    = wr_q;
    assign o_wreg  = wReg_q;
    assign o_wdata = oWdata_q;
    assign o_wstrb = oWstrb_q;
    assign o_rd    = rd_q;
    assign o_rreg  = rReg_q;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_bridge
//   Directed bench for axi_lite_reg_bridge with default parameters
//   (32-bit, 16 registers, base 0, mask ffff_ffc0). A small byte-enabled
//   register array stands in for the target: it drives i_rdata from o_rreg
//   and updates on o_wr. Single transactions come from a vector table;
//   reset, B back-pressure, W-before-AW and concurrent access with reset
//   are hand-written sequences. Inputs change and outputs are sampled on
//   the falling edge.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_bridge;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          expHit;
        logic [3:0]  expReg;
        logic [31:0] expData;
    } vec_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        oWr;
    logic        oRd;
    logic [3:0]  oWreg;
    logic [3:0]  oRreg;
    logic [31:0] oWdata;
    logic [3:0]  oWstrb;
    logic [31:0] iRdata;
    logic [31:0] tgt [16] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    axi_lite_reg_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_reg_bridge dut (
        .clk     (clk),
        .nreset  (nreset),
        .s       (bus),
        .o_wr    (oWr),
        .o_wreg  (oWreg),
        .o_wdata (oWdata),
        .o_wstrb (oWstrb),
        .o_rd    (oRd),
        .o_rreg  (oRreg),
        .i_rdata (iRdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Register target stand-in: combinational read, byte-enabled write on
    // the strobe edge, so a same-cycle read sees the old contents.
    assign iRdata = tgt[oRreg];
    always @(posedge clk) begin
        if (oWr) begin
            for (int b = 0; b < 4; b++) begin
                if (oWstrb[b]) tgt[oWreg][8*b +: 8] <= oWdata[8*b +: 8];
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // One complete read or write transaction with fixed minimum latency.
    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) begin
            checkOutput("awready before write", bus.s_awready, 1);
            checkOutput("wready before write", bus.s_wready, 1);
            bus.s_awaddr  = v.addr;
            bus.s_awvalid = 1'b1;
            bus.s_wdata   = v.data;
            bus.s_wstrb   = v.strb;
            bus.s_wvalid  = 1'b1;
            @(negedge clk);
            bus.s_awvalid = 1'b0;
            bus.s_wvalid  = 1'b0;
            checkOutput("o_wr strobe", oWr, v.expHit);
            if (v.expHit) begin
                checkOutput("o_wreg", oWreg, v.expReg);
                checkOutput("o_wdata", oWdata, v.expData);
                checkOutput("o_wstrb", oWstrb, v.strb);
            end
            checkOutput("bvalid during strobe", bus.s_bvalid, 0);
            @(negedge clk);
            checkOutput("bvalid", bus.s_bvalid, 1);
            checkOutput("bresp", bus.s_bresp, v.expHit ? 2'b00 : 2'b11);
            checkOutput("o_wr after strobe", oWr, 0);
            bus.s_bready = 1'b1;
            @(negedge clk);
            bus.s_bready = 1'b0;
            checkOutput("bvalid after handshake", bus.s_bvalid, 0);
        end else begin
            checkOutput("arready before read", bus.s_arready, 1);
            bus.s_araddr  = v.addr;
            bus.s_arvalid = 1'b1;
            @(negedge clk);
            bus.s_arvalid = 1'b0;
            checkOutput("o_rd strobe", oRd, v.expHit);
            if (v.expHit) checkOutput("o_rreg", oRreg, v.expReg);
            checkOutput("rvalid during strobe", bus.s_rvalid, 0);
            @(negedge clk);
            checkOutput("rvalid", bus.s_rvalid, 1);
            checkOutput("rresp", bus.s_rresp, v.expHit ? 2'b00 : 2'b11);
            checkOutput("rdata", bus.s_rdata, v.expData);
            checkOutput("o_rd after strobe", oRd, 0);
            bus.s_rready = 1'b1;
            @(negedge clk);
            bus.s_rready = 1'b0;
            checkOutput("rvalid after handshake", bus.s_rvalid, 0);
        end
    endtask

    initial begin
        vec_t vecs [15];
        vec_t rdBack;

        vecs[0]  = '{1'b1, 32'h0000_000C, 32'hCAFE_0001, 4'hF, 1'b1, 4'd3,  32'hCAFE_0001};
        vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 1'b1, 4'd3,  32'hCAFE_0001};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 4'd2,  32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 1'b1, 4'd1,  32'h0000_1234};
        vecs[4]  = '{1'b1, 32'h0000_001B, 32'h1122_3344, 4'h3, 1'b1, 4'd6,  32'h1122_3344};
        vecs[5]  = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 1'b1, 4'd6,  32'h0000_3344};
        vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b0, 4'd0,  32'h0000_0000};
        vecs[7]  = '{1'b1, 32'h0000_0040, 32'h9999_9999, 4'hF, 1'b0, 4'd0,  32'h0};
        vecs[8]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 1'b1, 4'd15, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 4'hC, 1'b1, 4'd15, 32'hA5A5_A5A5};
        vecs[10] = '{1'b0, 32'h0000_003E, 32'h0,         4'h0, 1'b1, 4'd15, 32'hA5A5_0000};
        vecs[11] = '{1'b1, 32'hFFFF_FFC8, 32'h5555_5555, 4'hF, 1'b0, 4'd0,  32'h0};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 4'd0,  32'h0000_0000};
        vecs[13] = '{1'b0, 32'h0000_000A, 32'h0,         4'h0, 1'b1, 4'd2,  32'hDEAD_BEEF};
        vecs[14] = '{1'b1, 32'h0000_0014, 32'h0BAD_F00D, 4'hF, 1'b1, 4'd5,  32'h0BAD_F00D};

        bus.s_awaddr  = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkOutput("reset awready", bus.s_awready, 0);
        checkOutput("reset wready", bus.s_wready, 0);
        checkOutput("reset arready", bus.s_arready, 0);
        checkOutput("reset bvalid", bus.s_bvalid, 0);
        checkOutput("reset rvalid", bus.s_rvalid, 0);
        checkOutput("reset bresp", bus.s_bresp, 0);
        checkOutput("reset rresp", bus.s_rresp, 0);
        checkOutput("reset rdata", bus.s_rdata, 0);
        checkOutput("reset o_wr", oWr, 0);
        checkOutput("reset o_rd", oRd, 0);
        checkOutput("reset o_wreg", oWreg, 0);
        checkOutput("reset o_rreg", oRreg, 0);
        checkOutput("reset o_wdata", oWdata, 0);
        checkOutput("reset o_wstrb", oWstrb, 0);
        nreset = 1'b1;
        #1;
        checkOutput("awready before first edge", bus.s_awready, 0);
        @(negedge clk);
        checkOutput("release awready", bus.s_awready, 1);
        checkOutput("release wready", bus.s_wready, 1);
        checkOutput("release arready", bus.s_arready, 1);
        checkOutput("release bvalid", bus.s_bvalid, 0);
        checkOutput("release rvalid", bus.s_rvalid, 0);
        checkOutput("release o_wr", oWr, 0);
        checkOutput("release o_rd", oRd, 0);

        $display("[TB] write with B back-pressure");
        bus.s_awaddr  = 32'h0000_0008;
        bus.s_awvalid = 1'b1;
        bus.s_wdata   = 32'hDEAD_BEEF;
        bus.s_wstrb   = 4'hF;
        bus.s_wvalid  = 1'b1;
        @(negedge clk);
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        checkOutput("stall o_wr", oWr, 1);
        checkOutput("stall o_wreg", oWreg, 2);
        checkOutput("stall o_wdata", oWdata, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("stall bvalid first", bus.s_bvalid, 1);
        checkOutput("stall bresp first", bus.s_bresp, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall bvalid held", bus.s_bvalid, 1);
            checkOutput("stall bresp held", bus.s_bresp, 0);
            checkOutput("stall no second o_wr", oWr, 0);
            checkOutput("stall awready low", bus.s_awready, 0);
        end
        bus.s_bready = 1'b1;
        @(negedge clk);
        bus.s_bready = 1'b0;
        checkOutput("stall bvalid released", bus.s_bvalid, 0);
        checkOutput("stall awready back", bus.s_awready, 1);

        $display("[TB] W before AW");
        bus.s_awaddr = 32'h0000_0004;
        bus.s_wdata  = 32'h0000_1234;
        bus.s_wstrb  = 4'hF;
        bus.s_wvalid = 1'b1;
        @(negedge clk);
        bus.s_wvalid = 1'b0;
        checkOutput("wfirst wready N+1", bus.s_wready, 0);
        checkOutput("wfirst awready N+1", bus.s_awready, 1);
        checkOutput("wfirst o_wr N+1", oWr, 0);
        @(negedge clk);
        checkOutput("wfirst wready N+2", bus.s_wready, 0);
        checkOutput("wfirst o_wr N+2", oWr, 0);
        @(negedge clk);
        checkOutput("wfirst wready N+3", bus.s_wready, 0);
        checkOutput("wfirst o_wr N+3", oWr, 0);
        bus.s_awvalid = 1'b1;
        @(negedge clk);
        bus.s_awvalid = 1'b0;
        checkOutput("wfirst o_wr N+4", oWr, 1);
        checkOutput("wfirst o_wreg", oWreg, 1);
        checkOutput("wfirst o_wdata", oWdata, 32'h0000_1234);
        @(negedge clk);
        checkOutput("wfirst single o_wr", oWr, 0);
        checkOutput("wfirst bvalid", bus.s_bvalid, 1);
        checkOutput("wfirst bresp", bus.s_bresp, 0);
        bus.s_bready = 1'b1;
        @(negedge clk);
        bus.s_bready = 1'b0;
        checkOutput("wfirst bvalid released", bus.s_bvalid, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

        $display("[TB] concurrent read and write of index 5, reset during R");
        bus.s_awaddr  = 32'h0000_0014;
        bus.s_awvalid = 1'b1;
        bus.s_wdata   = 32'h7777_7777;
        bus.s_wstrb   = 4'hF;
        bus.s_wvalid  = 1'b1;
        bus.s_araddr  = 32'h0000_0014;
        bus.s_arvalid = 1'b1;
        @(negedge clk);
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_arvalid = 1'b0;
        checkOutput("conc o_wr", oWr, 1);
        checkOutput("conc o_rd", oRd, 1);
        checkOutput("conc o_wreg", oWreg, 5);
        checkOutput("conc o_rreg", oRreg, 5);
        @(negedge clk);
        checkOutput("conc rvalid", bus.s_rvalid, 1);
        checkOutput("conc rdata pre-write", bus.s_rdata, 32'h0BAD_F00D);
        checkOutput("conc rresp", bus.s_rresp, 0);
        checkOutput("conc bvalid", bus.s_bvalid, 1);
        bus.s_bready = 1'b1;
        @(negedge clk);
        bus.s_bready = 1'b0;
        checkOutput("conc bvalid released", bus.s_bvalid, 0);
        checkOutput("conc rvalid held", bus.s_rvalid, 1);
        checkOutput("conc rdata held", bus.s_rdata, 32'h0BAD_F00D);
        nreset = 1'b0;
        #1;
        checkOutput("midreset rvalid", bus.s_rvalid, 0);
        checkOutput("midreset rdata", bus.s_rdata, 0);
        checkOutput("midreset arready", bus.s_arready, 0);
        checkOutput("midreset awready", bus.s_awready, 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post-reset o_rd", oRd, 0);
            checkOutput("post-reset o_wr", oWr, 0);
            checkOutput("post-reset rvalid", bus.s_rvalid, 0);
            checkOutput("post-reset bvalid", bus.s_bvalid, 0);
        end
        rdBack = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 1'b1, 4'd5, 32'h7777_7777};
        applyStimulus(rdBack);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
